rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (wen/waddr/wdata) between two writeback requesters: the ALU/EXU path and the LSU load path.
- Keeps a per-register busy scoreboard. Decode can then stall on RAW and WAW hazards until the pending write has landed in the register file.
- Sits between the execute/memory stages and RegisterFile. It drives RegisterFile's wen/waddr/wdata directly.

Parameters:
- DATA_WIDTH, 32, width of write data
- REG_NUM, 32, number of architectural registers
- REG_NUM_BIT, 5, register index width

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_waddr  in  REG_NUM_BIT  ALU destination register
- alu_wdata  in  DATA_WIDTH  ALU result
- lsu_valid  in  1  LSU writeback request
- lsu_ready  out  1  LSU request accepted this cycle
- lsu_waddr  in  REG_NUM_BIT  LSU destination register
- lsu_wdata  in  DATA_WIDTH  LSU load data
- issue_valid  in  1  decode issues an instruction that writes rd
- issue_ready  out  1  issue allowed (no WAW hazard)
- issue_rd  in  REG_NUM_BIT  destination of the issuing instruction
- rs1_addr  in  REG_NUM_BIT  source register 1 being read by decode
- rs2_addr  in  REG_NUM_BIT  source register 2 being read by decode
- rs_stall  out  1  a source register is busy; decode must hold
- rf_wen  out  1  to RegisterFile wen
- rf_waddr  out  REG_NUM_BIT  to RegisterFile waddr
- rf_wdata  out  DATA_WIDTH  to RegisterFile wdata

Behaviour:
- Reset (async, rst=1):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All busy bits cleared.
  - Round-robin pointer = ALU (ALU has priority first).
  - While rst=1, ready outputs = 0.
- Handshake:
  - A transfer occurs on a clock edge with valid&ready.
  - Requesters hold valid/waddr/wdata stable until accepted.
- Arbitration (combinational ready, registered output):
  - Only one requester valid: it gets ready=1.
  - Both valid: the side named by the RR pointer wins; the pointer flips to the other side after any grant.
  - Neither valid: pointer unchanged.
- Latency:
  - Grant accepted at edge N → rf_wen=1 with the winner's waddr/wdata during cycle N+1.
  - RegisterFile commits at edge N+1.
  - No grant → rf_wen=0 the next cycle; rf_waddr/rf_wdata hold their last values.
- x0 writes:
  - Accepted (ready asserted normally) but rf_wen forced 0.
  - x0 is never marked busy.
- Scoreboard:
  - busy[r] is set at the edge where issue_valid&issue_ready and issue_rd=r≠0.
  - busy[r] is cleared at the edge where rf_wen=1 and rf_waddr=r.
  - Set and clear of the same r on the same edge: set wins (new producer).
- issue_ready = !busy[issue_rd]. issue_rd=0 → issue_ready=1.
- rs_stall = (rs1_addr≠0 & busy[rs1_addr]) | (rs2_addr≠0 & busy[rs2_addr]).
- A writeback to a register that is not busy is legal: it writes, and the scoreboard is unchanged.
- Reset asserted mid-transfer: the pending registered write is dropped (rf_wen=0 immediately) and all busy bits clear.

Optional Feature:
- RF_WB_FWD_EN
- Defined:
  - Adds outputs fwd1_hit, fwd2_hit (1 bit each) and fwd_data (DATA_WIDTH).
  - fwdN_hit = rf_wen & rf_waddr==rsN_addr & rsN_addr≠0.
  - fwd_data = rf_wdata.
  - rs_stall ignores a busy register that hits forwarding this cycle, saving one stall cycle.
- Undefined:
  - The forwarding outputs are absent.
  - rs_stall holds until the busy bit clears, so the reader sees the data from the RegisterFile at N+2.

Decomposition:
- Package rf_arb_pkg holds:
  - REG_NUM_BIT, DATA_WIDTH, REG_NUM constants;
  - requester id enum {REQ_ALU=0, REQ_LSU=1};
  - the X0 index constant.
- Sub-module rf_scoreboard is the natural split: busy vector, set/clear/priority logic and the rs_stall/issue_ready lookups. The arbiter and output register stay in the top module.

Test Plan:
- Reset mid-run: busy[5]=1 and rf_wen=1 pending, assert rst → rf_wen=0 at once, busy all 0, rs_stall=0 for rs1=5.
- ALU only: alu_valid, waddr=3, wdata=0xDEADBEEF → alu_ready=1 same cycle; next cycle rf_wen=1, waddr=3, wdata=0xDEADBEEF.
- Contention: both valid for 2 cycles, ALU x1=0x11 and LSU x2=0x22 → ALU first, then LSU. rf writes in order x1 then x2, each with one-cycle latency.
- x0 write: lsu_valid, waddr=0 → lsu_ready=1, rf_wen stays 0, no busy change.
- Scoreboard RAW/WAW:
  - issue rd=7 → busy[7]=1, so rs1=7 gives rs_stall=1 and issue_rd=7 gives issue_ready=0.
  - After ALU writeback of x7 commits, both deassert (one cycle earlier with RF_WB_FWD_EN, fwd1_hit=1).
- Set/clear collision: rf_wen writing x9 while issue rd=9 on the same edge → busy[9] remains 1.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
//   DATA_WIDTH / REG_NUM / REG_NUM_BIT : default datapath and register-file geometry
//   req_id_e                           : writeback requester identity (round-robin pointer)
//   X0                                 : index of the hard-wired zero register
package rf_arb_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int REG_NUM     = 32;
  localparam int REG_NUM_BIT = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam logic [REG_NUM_BIT-1:0] X0 = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard used by decode for RAW/WAW hazard detection.
// Optional macro RF_WB_FWD_EN: a source that is being written back this cycle
// is forwarded instead of stalling, and the hit flags are exported.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   issue_valid/rd     : decode issuing an instruction that writes rd
//   issue_ready        : rd has no pending producer (no WAW hazard)
//   rs1_addr, rs2_addr : sources being read by decode
//   rs_stall           : a source is still waiting for its producer
//   wb_wen, wb_waddr   : write currently being presented to the register file
//   fwd1_hit, fwd2_hit : (RF_WB_FWD_EN only) source matches the in-flight write
module rf_scoreboard #(
  parameter int REG_NUM     = rf_arb_pkg::REG_NUM,
  parameter int REG_NUM_BIT = rf_arb_pkg::REG_NUM_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [REG_NUM_BIT-1:0] issue_rd,
  output logic                   issue_ready,
  input  logic [REG_NUM_BIT-1:0] rs1_addr,
  input  logic [REG_NUM_BIT-1:0] rs2_addr,
  output logic                   rs_stall,
`ifdef RF_WB_FWD_EN
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
`endif
  input  logic                   wb_wen,
  input  logic [REG_NUM_BIT-1:0] wb_waddr
);
  import rf_arb_pkg::*;

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic               set_en;
  logic               rs1_busy;
  logic               rs2_busy;

  assign issue_ready = !busy_q[issue_rd];
  assign set_en      = issue_valid && issue_ready && (issue_rd != X0);

  // Clear first, then set, so a new producer issued on the same edge as the
  // old producer's writeback keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_wen) busy_d[wb_waddr] = 1'b0;
    if (set_en) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rs1_busy = (rs1_addr != X0) && busy_q[rs1_addr];
  assign rs2_busy = (rs2_addr != X0) && busy_q[rs2_addr];

`ifdef RF_WB_FWD_EN
  assign fwd1_hit = wb_wen && (wb_waddr == rs1_addr) && (rs1_addr != X0);
  assign fwd2_hit = wb_wen && (wb_waddr == rs2_addr) && (rs2_addr != X0);
  assign rs_stall = (rs1_busy && !fwd1_hit) || (rs2_busy && !fwd2_hit);
`else
  assign rs_stall = rs1_busy || rs2_busy;
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between the
// ALU and LSU writeback paths, plus the busy scoreboard used by decode.
// Optional macro RF_WB_FWD_EN adds fwd1_hit/fwd2_hit/fwd_data forwarding outputs.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   alu_valid/ready/waddr/wdata    : ALU writeback handshake
//   lsu_valid/ready/waddr/wdata    : LSU writeback handshake
//   issue_valid/ready, issue_rd    : decode destination-register reservation
//   rs1_addr, rs2_addr, rs_stall   : decode source-register hazard lookup
//   fwd1_hit, fwd2_hit, fwd_data   : (RF_WB_FWD_EN only) bypass of the in-flight write
//   rf_wen, rf_waddr, rf_wdata     : registered write port to RegisterFile
module rf_wb_arbiter #(
  parameter int DATA_WIDTH  = rf_arb_pkg::DATA_WIDTH,
  parameter int REG_NUM     = rf_arb_pkg::REG_NUM,
  parameter int REG_NUM_BIT = rf_arb_pkg::REG_NUM_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_NUM_BIT-1:0] alu_waddr,
  input  logic [DATA_WIDTH-1:0]  alu_wdata,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [REG_NUM_BIT-1:0] lsu_waddr,
  input  logic [DATA_WIDTH-1:0]  lsu_wdata,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [REG_NUM_BIT-1:0] issue_rd,
  input  logic [REG_NUM_BIT-1:0] rs1_addr,
  input  logic [REG_NUM_BIT-1:0] rs2_addr,
  output logic                   rs_stall,
`ifdef RF_WB_FWD_EN
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [DATA_WIDTH-1:0]  fwd_data,
`endif
  output logic                   rf_wen,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]  rf_wdata
);
  import rf_arb_pkg::*;

  req_id_e                rr_ptr;
  logic                   vld_p1;
  logic [REG_NUM_BIT-1:0] waddr_p1;
  logic [DATA_WIDTH-1:0]  wdata_p1;

  // Stage 0: combinational grant. A lone requester always wins; on contention
  // the pointer decides. Ready is held low while reset is asserted.
  assign alu_ready = !rst && alu_valid && (!lsu_valid || (rr_ptr == REQ_ALU));
  assign lsu_ready = !rst && lsu_valid && (!alu_valid || (rr_ptr == REQ_LSU));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_ptr <= REQ_ALU;
    else if (alu_ready) rr_ptr <= REQ_LSU;
    else if (lsu_ready) rr_ptr <= REQ_ALU;
  end

  // Stage 1: registered write port. x0 writes are accepted but never strobe
  // wen; address/data hold their last value when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= (alu_ready && (alu_waddr != X0)) ||
                (lsu_ready && (lsu_waddr != X0));
      if (alu_ready) begin
        waddr_p1 <= alu_waddr;
        wdata_p1 <= alu_wdata;
      end else if (lsu_ready) begin
        waddr_p1 <= lsu_waddr;
        wdata_p1 <= lsu_wdata;
      end
    end
  end

  assign rf_wen   = vld_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;

`ifdef RF_WB_FWD_EN
  assign fwd_data = wdata_p1;
`endif

  rf_scoreboard #(
    .REG_NUM     (REG_NUM),
    .REG_NUM_BIT (REG_NUM_BIT)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs_stall    (rs_stall),
`ifdef RF_WB_FWD_EN
    .fwd1_hit    (fwd1_hit),
    .fwd2_hit    (fwd2_hit),
`endif
    .wb_wen      (vld_p1),
    .wb_waddr    (waddr_p1)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter with a write-port scoreboard queue and
// a reference model of the round-robin pointer and busy bits.
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic        alu_ready, lsu_ready, issue_ready, rs_stall;
  logic [4:0]  alu_waddr, lsu_waddr, issue_rd, rs1_addr, rs2_addr;
  logic [31:0] alu_wdata, lsu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef RF_WB_FWD_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd_data;
`endif

  int passed = 0;
  int total  = 0;

  wb_t         exp_q[$];
  wb_t         cur;       // model of what the DUT write port shows now
  logic        rr;        // 0 = ALU favoured, 1 = LSU favoured
  logic [31:0] mb;        // model busy bits

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_waddr   (alu_waddr),
    .alu_wdata   (alu_wdata),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_waddr   (lsu_waddr),
    .lsu_wdata   (lsu_wdata),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs_stall    (rs_stall),
`ifdef RF_WB_FWD_EN
    .fwd1_hit    (fwd1_hit),
    .fwd2_hit    (fwd2_hit),
    .fwd_data    (fwd_data),
`endif
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr  = 1'b0;
    mb  = '0;
    cur = '0;
    exp_q.delete();
  endtask

  // Inputs are already driven (at posedge+1). Check combinational outputs
  // against the model, push the expected write-port state, clock once and
  // compare the write port against the popped entry.
  task automatic tick();
    logic ga, gl, iok, f1, f2, stall;
    wb_t  nxt;
    wb_t  got;
    #1;
    ga = alu_valid && (!lsu_valid || rr == 1'b0);
    gl = lsu_valid && (!alu_valid || rr == 1'b1);
    chk("alu_ready", alu_ready, ga);
    chk("lsu_ready", lsu_ready, gl);
    iok = !mb[issue_rd];
    chk("issue_ready", issue_ready, iok);
`ifdef RF_WB_FWD_EN
    f1 = cur.wen && cur.addr == rs1_addr && rs1_addr != 0;
    f2 = cur.wen && cur.addr == rs2_addr && rs2_addr != 0;
    chk("fwd1_hit", fwd1_hit, f1);
    chk("fwd2_hit", fwd2_hit, f2);
    if (f1 || f2) chk("fwd_data", fwd_data, cur.data);
`else
    f1 = 1'b0;
    f2 = 1'b0;
`endif
    stall = (rs1_addr != 0 && mb[rs1_addr] && !f1) || (rs2_addr != 0 && mb[rs2_addr] && !f2);
    chk("rs_stall", rs_stall, stall);
    if (ga)      nxt = '{wen: alu_waddr != 0, addr: alu_waddr, data: alu_wdata};
    else if (gl) nxt = '{wen: lsu_waddr != 0, addr: lsu_waddr, data: lsu_wdata};
    else         nxt = '{wen: 1'b0, addr: cur.addr, data: cur.data};
    exp_q.push_back(nxt);
    if (ga)      rr = 1'b1;
    else if (gl) rr = 1'b0;
    if (cur.wen) mb[cur.addr] = 1'b0;
    if (issue_valid && iok && issue_rd != 0) mb[issue_rd] = 1'b1;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 64'd1, 64'd0);
    end else begin
      got = exp_q.pop_front();
      chk("rf_wen", rf_wen, got.wen);
      chk("rf_waddr", rf_waddr, got.addr);
      chk("rf_wdata", rf_wdata, got.data);
      cur = got;
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_waddr = 0; alu_wdata = 0;
    lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
    issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    alu_valid = 1; lsu_valid = 1; rs1_addr = 5'd1;
    #1;
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_lsu_ready", lsu_ready, 1'b0);
    chk("rst_rs_stall", rs_stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();

    // Contention: ALU x1 wins first, LSU x2 second, then ALU alone with x4.
    alu_valid = 1; alu_waddr = 5'd1; alu_wdata = 32'h11;
    lsu_valid = 1; lsu_waddr = 5'd2; lsu_wdata = 32'h22;
    tick();
    chk("cont_first_x1", rf_waddr, 5'd1);
    alu_waddr = 5'd4; alu_wdata = 32'h44;
    tick();
    chk("cont_second_x2", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd2, 32'h22});
    lsu_valid = 0;
    tick();
    alu_valid = 0;
    tick();

    // ALU only: x3 = DEADBEEF, then idle so the port holds its values.
    alu_valid = 1; alu_waddr = 5'd3; alu_wdata = 32'hDEADBEEF;
    tick();
    chk("alu_only_data", rf_wdata, 32'hDEADBEEF);
    alu_valid = 0;
    tick();
    chk("idle_hold_addr", rf_waddr, 5'd3);

    // LSU x0 write: accepted, no strobe, no busy change.
    lsu_valid = 1; lsu_waddr = 5'd0; lsu_wdata = 32'hCAFE0000; rs1_addr = 5'd0;
    tick();
    chk("x0_no_wen", rf_wen, 1'b0);
    lsu_valid = 0; issue_rd = 5'd0;
    tick();

    // Scoreboard: reserve x7, then see RAW and WAW hazards on it.
    issue_valid = 1; issue_rd = 5'd7;
    tick();
    issue_valid = 0; rs1_addr = 5'd7;
    tick();
    chk("raw_stall_x7", rs_stall, 1'b1);
    alu_valid = 1; alu_waddr = 5'd7; alu_wdata = 32'h7777_0007;
    tick();
    alu_valid = 0;
    tick();   // rf_wen for x7 is visible during this tick's pre-edge checks
    tick();
    chk("x7_released", {rs_stall, issue_ready}, 2'b01);

    // Set/clear collision: write non-busy x9 while x9 is issued on the same edge.
    rs1_addr = 5'd0; rs2_addr = 5'd9; issue_rd = 5'd9;
    alu_valid = 1; alu_waddr = 5'd9; alu_wdata = 32'h99;
    tick();
    alu_valid = 0; issue_valid = 1;
    tick();
    issue_valid = 0;
    tick();
    chk("collision_busy9", rs_stall, 1'b1);

    // Reset mid-run: x5 busy and a write to x6 pending on the port.
    issue_valid = 1; issue_rd = 5'd5; rs2_addr = 5'd0;
    alu_valid = 1; alu_waddr = 5'd6; alu_wdata = 32'h66;
    tick();
    chk("pre_rst_wen", rf_wen, 1'b1);
    issue_valid = 0; alu_valid = 1; rs1_addr = 5'd5;
    rst = 1'b1;
    #1;
    chk("midrst_rf_wen", rf_wen, 1'b0);
    chk("midrst_rs_stall", rs_stall, 1'b0);
    chk("midrst_issue_ready", issue_ready, 1'b1);
    chk("midrst_alu_ready", alu_ready, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    rs1_addr = 5'd5; issue_rd = 5'd5;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
